inverse_shift_sub_bytes: RTL
============================

// Module: inverse_shift_sub_bytes
// PURPOSE
// - Iterative AES-128 decryption stage: InvShiftRows followed by InvSubBytes on one 128-bit state.
// - Sits directly upstream of the round-key add / inverse_mix_columns path in the decryption round.
// - Its registered out feeds that path.
// - Trades area for latency: LANES inverse S-box instances are time-shared over 16/LANES cycles.
// - Uses start/busy/done handshaking.
// PARAMETERS
// - LANES   4   bytes substituted per cycle.
//   - Legal values: 1, 2, 4, 8, 16.
//   - N = 16/LANES processing cycles.
// PORTS
// - clk      input   1    single clock, rising edge.
// - reset_n  input   1    reset, asynchronous assert, active-low; everything clears immediately.
// - start    input   1    request.
//   - Sampled on a rising edge while busy=0.
//   - in is captured on that same edge.
// - in       input   128  state.
//   - byte i = in[127-8i -: 8].
//   - State element s[r][c] = byte 4c+r (column-major).
// - busy     output  1    high while a transform is in progress.
// - done     output  1    one-cycle pulse: out has just been updated.
// - out      output  128  result in the same byte layout; holds until the next completion.
// BEHAVIOUR
// - Reset: busy=0, done=0, out=128'h0, work register=0, counter=0, FSM=IDLE.
//   - A reset mid-operation aborts the transform. out does not update. done does not pulse.
// - FSM states: IDLE, PROC.
// - IDLE, start=1 at edge E0:
//   - work <= InvShiftRows(in), i.e. s'[r][c] = s[r][(c-r) mod 4].
//   - cnt <= 0, busy <= 1, go to PROC.
// - IDLE, start=0: hold. done is 0 in every cycle except the completion pulse.
// - PROC, each edge k = 1..N:
//   - Bytes cnt*LANES .. cnt*LANES+LANES-1 of work are replaced by InvSbox(byte).
//   - cnt increments.
// - At edge N (last chunk):
//   - out <= work with the final chunk substituted.
//   - done <= 1 (for exactly one cycle), busy <= 0, cnt <= 0, go to IDLE.
// - Latency: done high and out valid in the cycle after edge E0+N (LANES=4: 4 clocks).
// - start while busy=1 is ignored; in is not re-sampled.
// - start in the done cycle is accepted (busy=0). Back-to-back throughput is 1 per N+1 cycles.
// - out changes only at a completion edge. Intermediate work contents are never visible on out.
// - The byte-select counter is ceil(log2(N)) bits wide, min 1 bit.
//   - It never wraps past N-1. For LANES=16, PROC lasts one edge.
// - InvSbox(x) = multiplicative inverse in GF(2^8), modulo x^8+x^4+x^3+x+1, applied after the inverse affine map.
//   - The inverse of 0 is 0.
//   - Must equal the FIPS-197 inverse S-box table for all 256 inputs.
//   - Either a ROM or the arithmetic form is acceptable. It must be purely combinational.
// TESTING
// - Reset: assert reset_n=0 mid-PROC -> busy=0, done=0, out=0 immediately; no done pulse afterwards.
// - FIPS-197 App. C inverse round 1:
//   - Stimulus: in=7ad5fda789ef4e272bca100b3d9ff59f, start for 1 cycle.
//   - Required: out=bd6e7c3df2b5779e0b61216e8b10b689 with a single done pulse N cycles after the start edge.
// - Constants:
//   - in=all 8'h63 -> out=all 8'h00.
//   - in=all 8'h00 -> out=all 8'h52.
//   - in=all 8'h16 -> out=all 8'hff.
// - Busy protection:
//   - Stimulus: start with vector A, then start=1 with vector B on every cycle while busy.
//   - Required: out=result(A); then B is accepted only when busy=0; B completes N+1 cycles later.
// - Back-to-back: start asserted during the done cycle -> accepted; second done occurs N+1 cycles after the first.
// - Exhaustive S-box: 16 runs, each covering 16 distinct byte values, with InvShiftRows pre-compensated.
//   - Required: all 256 outputs match the FIPS table.
//   - Run the full regression at LANES=1, 4 and 16.

Source files
------------

// File: rtl/inverse_shift_sub_bytes.sv
// AES-128 decryption stage: InvShiftRows followed by InvSubBytes, with LANES
// inverse S-boxes time-shared over 16/LANES cycles behind a start/busy/done handshake.

// state | meaning
// IDLE  | waiting for start; out holds the last completed result
// PROC  | substituting one LANES-byte chunk of the work register per cycle

module inv_sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);
   function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] z);
      logic [7:0] acc;
      logic [7:0] b;
      logic [7:0] m;
      acc = 8'h00;
      b   = x;
      m   = z;
      for (int i = 0; i < 8; i++) begin
         if (m[0]) acc = acc ^ b;
         b = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
         m = m >> 1;
      end
      return acc;
   endfunction

   logic [7:0] t;
   logic [7:0] p2, p4, p8, p16, p32, p64, p128;

   // Inverse affine first, then x^254 (= x^-1, and 0 maps to 0).
   always_comb begin
      t    = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
      p2   = gf_mul(t, t);
      p4   = gf_mul(p2, p2);
      p8   = gf_mul(p4, p4);
      p16  = gf_mul(p8, p8);
      p32  = gf_mul(p16, p16);
      p64  = gf_mul(p32, p32);
      p128 = gf_mul(p64, p64);
      y    = gf_mul(gf_mul(gf_mul(p2, p4), gf_mul(p8, p16)),
                    gf_mul(gf_mul(p32, p64), p128));
   end
endmodule

module inverse_shift_sub_bytes #(
   parameter int LANES = 4
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start,
   input  logic [127:0] in,
   output logic         busy,
   output logic         done,
   output logic [127:0] out
);
   localparam int N  = 16 / LANES;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   typedef enum logic {IDLE, PROC} state_t;

   state_t                     state_q, state_d;
   logic [0:N-1][8*LANES-1:0]  work_q, work_d, work_sub;
   logic [127:0]               out_q, out_d;
   logic [CW-1:0]              cnt_q, cnt_d;
   logic                       busy_q, busy_d;
   logic                       done_q, done_d;

   logic [0:15][7:0]           in_b, in_isr;
   logic [8*LANES-1:0]         chunk, chunk_sub;

   assign in_b = in;

   // s'[r][c] = s[r][(c-r) mod 4], bytes column-major (byte 4c+r).
   for (genvar c = 0; c < 4; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         assign in_isr[4*c+r] = in_b[4*((c-r+4)%4)+r];
      end
   end

   // Work register is viewed as N chunks so the counter selects a chunk directly.
   assign chunk = work_q[cnt_q];

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      inv_sbox u_inv_sbox (
         .a (chunk[8*(LANES-1-l) +: 8]),
         .y (chunk_sub[8*(LANES-1-l) +: 8])
      );
   end

   always_comb begin
      work_sub        = work_q;
      work_sub[cnt_q] = chunk_sub;
   end

   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      out_d   = out_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               work_d  = in_isr;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = PROC;
            end
         end
         PROC: begin
            work_d = work_sub;
            if (cnt_q == CNT_LAST) begin
               out_d   = work_sub;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         work_q  <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         out_q   <= out_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign out  = out_q;
endmodule
